// File: rtl/rr_mux_pkg.sv
// rr_mux_pkg: shared mode constants and width helper for the round-robin mux arbiter.
package rr_mux_pkg;
  localparam logic MODE_SEL = 1'b0;
  localparam logic MODE_RR  = 1'b1;
  function automatic int clog2(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 32; i++) if ((1 << i) < n) r = i + 1;
    return r;
  endfunction
endpackage

// File: rtl/rr_mux_arb_grant.sv
// rr_grant: rotating-priority encoder, searching from last+1 upward with wrap.
module rr_grant
  import rr_mux_pkg::*;
#(
  parameter int NCH = 8,
  localparam int SELW = clog2(NCH)
) (
  input  logic [NCH-1:0]  req,
  input  logic [SELW-1:0] last,
  output logic [SELW-1:0] grant,
  output logic            gvalid
);
  int start;
  logic [2*NCH-1:0] dbl;
  logic [NCH-1:0] rot;
  always_comb begin
    start = (int'(last) + 1) % NCH;
    dbl = {req, req} >> start;
    rot = dbl[NCH-1:0];
    gvalid = |req;
    grant = '0;
    for (int i = NCH - 1; i >= 0; i--) if (rot[i]) grant = SELW'((start + i) % NCH);
  end
endmodule

// File: rtl/rr_mux_arb.sv
// rr_mux_arb: NCH-channel mux with explicit-select or round-robin arbitration into a registered valid/ready output.
module rr_mux_arb
  import rr_mux_pkg::*;
#(
  parameter int NCH = 8,
  parameter int W = 8,
  localparam int SELW = clog2(NCH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mode,
  input  logic [SELW-1:0]   sel,
  input  logic [NCH-1:0]    in_valid,
  input  logic [NCH*W-1:0]  in_data,
  output logic [NCH-1:0]    in_ready,
  output logic              out_valid,
  output logic [W-1:0]      out_data,
  output logic [SELW-1:0]   out_ch,
  input  logic              out_ready
);
  logic out_valid_q, out_valid_d;
  logic [W-1:0] out_data_q, out_data_d;
  logic [SELW-1:0] out_ch_q, out_ch_d, last_q, last_d;
  logic [SELW-1:0] rr_gnt, grant;
  logic rr_gvalid, sel_ok, gvalid, load, xfer;
  rr_grant #(.NCH(NCH)) u_grant (
    .req(in_valid),
    .last(last_q),
    .grant(rr_gnt),
    .gvalid(rr_gvalid)
  );
  always_comb begin
    load = !out_valid_q || out_ready;
    // shifting a 1 past NCH yields zero, so out-of-range sel never grants
    sel_ok = (int'(sel) < NCH) && |(in_valid & (NCH'(1) << sel));
    grant = (mode == MODE_RR) ? rr_gnt : sel;
    gvalid = (mode == MODE_RR) ? rr_gvalid : sel_ok;
    in_ready = (!rst && load && gvalid) ? (NCH'(1) << grant) : '0;
    xfer = |(in_valid & in_ready);
    out_valid_d = load ? xfer : out_valid_q;
    out_data_d = xfer ? in_data[int'(grant) * W +: W] : out_data_q;
    out_ch_d = xfer ? grant : out_ch_q;
    last_d = (xfer && mode == MODE_RR) ? grant : last_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q <= '0;
      out_ch_q <= '0;
      last_q <= SELW'(NCH - 1);
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q <= out_data_d;
      out_ch_q <= out_ch_d;
      last_q <= last_d;
    end
  end
  assign out_valid = out_valid_q;
  assign out_data = out_data_q;
  assign out_ch = out_ch_q;
endmodule

// File: tb/tb_rr_mux_arb.sv
// tb_rr_mux_arb: directed stimulus with a queue scoreboard on the 8-channel instance plus direct checks on a 5-channel instance.
module tb_rr_mux_arb;
  logic clk = 1'b0, rst = 1'b1;
  logic mode = 1'b1, out_ready = 1'b1;
  logic [2:0] sel = '0;
  logic [7:0] in_valid = 8'hFF, in_ready;
  logic [63:0] in_data;
  logic out_valid;
  logic [7:0] out_data;
  logic [2:0] out_ch;
  logic mode5 = 1'b0, out_ready5 = 1'b1;
  logic [2:0] sel5 = '0;
  logic [4:0] in_valid5 = '0, in_ready5;
  logic [39:0] in_data5;
  logic out_valid5;
  logic [7:0] out_data5;
  logic [2:0] out_ch5;
  logic [10:0] q[$];
  int total = 0, bad = 0;

  rr_mux_arb #(.NCH(8), .W(8)) u8 (
    .clk(clk), .rst(rst), .mode(mode), .sel(sel), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data), .out_ch(out_ch), .out_ready(out_ready)
  );
  rr_mux_arb #(.NCH(5), .W(8)) u5 (
    .clk(clk), .rst(rst), .mode(mode5), .sel(sel5), .in_valid(in_valid5), .in_data(in_data5),
    .in_ready(in_ready5), .out_valid(out_valid5), .out_data(out_data5), .out_ch(out_ch5), .out_ready(out_ready5)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_word(input int ch, input logic [7:0] data);
    q.push_back({3'(ch), data});
  endtask

  initial begin
    for (int c = 0; c < 8; c++) in_data[c*8 +: 8] = 8'hA0 + 8'(c);
    for (int c = 0; c < 5; c++) in_data5[c*8 +: 8] = 8'hB0 + 8'(c);
  end

  initial begin : monitor
    logic [10:0] e;
    forever begin
      @(negedge clk);
      if (!rst && out_valid) begin
        total++;
        if (q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_word: got ch=%0d data=%h expected none", out_ch, out_data);
        end else begin
          e = q[0];
          if ({out_ch, out_data} !== e) begin
            bad++;
            $display("FAIL word: got ch=%0d data=%h expected ch=%0d data=%h", out_ch, out_data, e[10:8], e[7:0]);
          end
          if (out_ready) void'(q.pop_front());
        end
      end
    end
  end

  initial begin
    tick;
    chk("rst_in_ready0", 32'(in_ready), 0);
    chk("rst_out_valid0", 32'(out_valid), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_out_ch", 32'(out_ch), 0);
    tick;
    chk("rst_in_ready1", 32'(in_ready), 0);
    chk("rst_out_valid1", 32'(out_valid), 0);
    rst = 1'b0;
    #1;
    chk("first_grant_ch0", 32'(in_ready), 32'h01);
    for (int i = 0; i < 16; i++) begin
      expect_word(i % 8, 8'hA0 + 8'(i % 8));
      tick;
      chk("rr_no_bubble", 32'(out_valid), 1);
    end
    mode = 1'b0;
    for (int s = 0; s < 8; s++) begin
      sel = 3'(s);
      expect_word(s, 8'hA0 + 8'(s));
      tick;
      chk("sel_no_bubble", 32'(out_valid), 1);
    end
    mode = 1'b1;
    in_valid = 8'b1001_0100;
    expect_word(2, 8'hA2); tick;
    expect_word(4, 8'hA4); tick;
    expect_word(7, 8'hA7); tick;
    expect_word(2, 8'hA2); tick;
    in_valid = 8'b1000_0100;
    expect_word(7, 8'hA7); tick;
    expect_word(2, 8'hA2); tick;
    in_valid = 8'hFF;
    in_data[3*8 +: 8] = 8'h55;
    expect_word(3, 8'h55); tick;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_in_ready", 32'(in_ready), 0);
      tick;
      chk("stall_data", 32'(out_data), 32'h55);
    end
    out_ready = 1'b1;
    #1;
    chk("after_stall_grant", 32'(in_ready), 32'h10);
    expect_word(4, 8'hA4); tick;
    chk("after_stall_no_bubble", 32'(out_valid), 1);
    out_ready = 1'b0;
    mode = 1'b0;
    sel = 3'd1;
    #1;
    chk("modesw_in_ready", 32'(in_ready), 0);
    tick;
    chk("modesw_hold_data", 32'(out_data), 32'hA4);
    chk("modesw_hold_ch", 32'(out_ch), 4);
    rst = 1'b1;
    q.delete();
    #1;
    chk("midrst_in_ready", 32'(in_ready), 0);
    tick;
    chk("midrst_out_valid", 32'(out_valid), 0);
    rst = 1'b0;
    mode = 1'b1;
    out_ready = 1'b1;
    in_valid = 8'h01;
    expect_word(0, 8'hA0); tick;
    in_valid = 8'h00;
    tick;
    chk("drain_out_valid", 32'(out_valid), 0);
    in_valid5 = 5'h1F;
    sel5 = 3'd1;
    #1;
    chk("n5_sel1_ready", 32'(in_ready5), 32'h02);
    tick;
    chk("n5_sel1_valid", 32'(out_valid5), 1);
    chk("n5_sel1_data", 32'(out_data5), 32'hB1);
    chk("n5_sel1_ch", 32'(out_ch5), 1);
    sel5 = 3'd4;
    #1;
    chk("n5_sel4_ready", 32'(in_ready5), 32'h10);
    tick;
    chk("n5_sel4_data", 32'(out_data5), 32'hB4);
    chk("n5_sel4_ch", 32'(out_ch5), 4);
    sel5 = 3'd6;
    #1;
    chk("n5_sel6_ready", 32'(in_ready5), 0);
    tick;
    chk("n5_sel6_drain", 32'(out_valid5), 0);
    tick;
    chk("queue_empty", 32'(q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/rr_mux_arb.md
Name: rr_mux_arb

Overview:
- Parametrised successor to the gate-level 8x1 multiplexer: NCH channels, each W bits wide.
- Output is a single registered word with a valid/ready handshake.
- Two modes: explicit select, or round-robin arbitration among valid channels.
- Sits in front of shared single-consumer resources (bus, serialiser) that several producers feed.

Parameters:
- NCH, 8, number of input channels (2..16).
- W, 8, data width per channel in bits.
- SELW, clog2(NCH), width of channel index; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- mode  input  1  0 = select mode, 1 = round-robin mode.
- sel  input  SELW  channel index used in select mode.
- in_valid  input  NCH  per-channel valid; bit c is channel c.
- in_data  input  NCH*W  channel c occupies bits [c*W +: W].
- in_ready  output  NCH  per-channel accept, at most one bit high.
- out_valid  output  1  output register holds a word.
- out_data  output  W  registered data.
- out_ch  output  SELW  index of the channel that supplied out_data.
- out_ready  input  1  consumer accepts out_data this cycle.

Behaviour:
- Reset (rst=1 at a clk edge):
  - out_valid=0, out_data=0, out_ch=0.
  - Round-robin pointer last=NCH-1, so channel 0 has highest priority first.
  - in_ready must be all 0 while rst is high.
  - Reset mid-transfer discards the held word; nothing is replayed.
- Definitions:
  - load = !out_valid || out_ready (the output register can take a word this cycle).
  - grant = channel chosen this cycle; gvalid = a grant exists.
- Select mode (mode=0):
  - gvalid = (sel < NCH) && in_valid[sel]; grant = sel.
  - sel >= NCH (non-power-of-two NCH) gives no grant and is not an error.
- Round-robin mode (mode=1):
  - grant = first c with in_valid[c], searching last+1, last+2, ... modulo NCH, wrapping.
  - gvalid = |in_valid.
- in_ready[c] = !rst && load && gvalid && (grant==c). Purely combinational; no dependency on in_valid[c] beyond the grant logic.
- Transfer: when in_valid[grant] && in_ready[grant], at the clk edge:
  - out_data <= channel's data; out_ch <= grant; out_valid <= 1.
  - If mode=1, last <= grant.
- last updates only on an accepted transfer.
  - It is unchanged in select mode and unchanged when stalled.
  - It is preserved across mode switches.
- Latency: 1 cycle from input acceptance to out_valid.
- Throughput: 1 word/cycle when out_ready is held high.
- Stall: out_valid && !out_ready means out_data and out_ch hold stable and in_ready is all 0.
- Drain: load && !gvalid means out_valid <= 0; out_data and out_ch keep their last value (don't-care).
- Simultaneous consume and refill: out_ready=1 with a valid grant in the same cycle replaces the word with no bubble.
- mode and sel are sampled every cycle.
  - A change affects only the next grant decision.
  - A held output word is never altered by a change.
- Inputs are not held by the block. A producer must keep in_valid and in_data stable until it sees in_ready.

Decomposition:
- Shared package rr_mux_pkg holds:
  - MODE_SEL=1'b0 and MODE_RR=1'b1 constants.
  - A clog2 function used to derive SELW.
- One sub-module, rr_grant: combinational rotating-priority encoder.
  - Inputs: req[NCH], last[SELW].
  - Outputs: grant[SELW], gvalid.
  - Implement as a double-width request vector rotated by last+1, then a priority encode.
- The top module holds the output register, the pointer register, the select-mode path and the in_ready decode.

Test Plan:
- Reset: assert rst for 2 cycles with all in_valid=1 -> in_ready=0 and out_valid=0 throughout; first grant after release (mode=1) is ch0.
- Select sweep (NCH=8, W=8): mode=0, in_data[c]=8'hA0+c, all valid, out_ready=1; step sel 0..7 one per cycle -> out_data follows 8'hA0..8'hA7 one cycle later, out_ch=sel, no bubbles.
- Round-robin fairness: mode=1, in_valid=8'b1111_1111, out_ready=1 for 16 cycles -> out_ch sequence 0,1,...,7,0,...,7; wrap from ch7 to ch0 correct.
- Sparse round-robin: in_valid=8'b1001_0100 (ch2, ch4, ch7), last=7 -> grants 2,4,7,2; deassert ch4 mid-stream -> next grant after 2 is 7.
- Backpressure: out_ready=0 for 3 cycles after out_valid rises with out_data=8'h55 -> out_data stays 8'h55, in_ready=0, pointer unchanged; out_ready=1 -> next channel loads with no bubble.
- Corner cases:
  - NCH=5, mode=0, sel=6 -> no transfer, out_valid drains to 0.
  - Switch mode 1->0 mid-stall -> held word unchanged; reset mid-stall -> out_valid=0 next cycle.
